// File: rtl/data_link_pkg.sv
// Shared constants and types for the triggered 18-bit switch-word link.
// Used by both the sender (data_program) and the receiver (data_receive).
package data_link_pkg;

    localparam int WORD_W          = 18;
    localparam int FLAG_MIN_DEF    = 500;
    localparam int GAP_CYCLES_DEF  = 1000;
    localparam int END_TIMEOUT_DEF = 2000;

    localparam int CNT_W = 14;
    localparam int IDX_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        GAP,
        SHIFT,
        WAIT_END,
        END,
        DRAIN
    } rx_state_e;

    // One counter serves every state; it pins at CNT_MAX instead of wrapping
    // so an endless flag can never alias back into a short one.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/data_receive_if.sv
// Serial link pins plus the received-word side toward DDS-update logic.
interface data_receive_if;
    import data_link_pkg::*;

    logic              data_in;
    logic              dflag_in;
    logic [WORD_W-1:0] rx_word;
    logic              word_valid;
    logic              frame_error;
    logic              busy;

    modport master (
        output data_in, dflag_in,
        input  rx_word, word_valid, frame_error, busy
    );

    modport slave (
        input  data_in, dflag_in,
        output rx_word, word_valid, frame_error, busy
    );

endinterface

// File: rtl/data_receive_sync2.sv
// Two-flop synchronizer; both link inputs use one so their latency matches.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] pipe;

    always_ff @(posedge clk) begin
        if (reset) pipe <= '0;
        else       pipe <= {pipe[0], d};
    end

    assign q = pipe[1];

endmodule

// File: rtl/data_receive.sv
// Receive-side deserializer: qualifies start flag, fixed gap, 18 LSB-first
// data bits and end flag, then publishes the word with a one-cycle strobe.
module data_receive
    import data_link_pkg::*;
#(
    parameter int FLAG_MIN    = FLAG_MIN_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int END_TIMEOUT = END_TIMEOUT_DEF
) (
    input  logic          TenMHzToData,
    input  logic          reset,
    data_receive_if.slave rx
);
    localparam logic [CNT_W-1:0] FLAG_CNT = CNT_W'(FLAG_MIN);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(END_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WORD_W - 1);

    logic d_s, f_s;

    sync2 u_sync_data (.clk(TenMHzToData), .reset(reset), .d(rx.data_in),  .q(d_s));
    sync2 u_sync_flag (.clk(TenMHzToData), .reset(reset), .d(rx.dflag_in), .q(f_s));

    rx_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] rx_word_q;
    logic              word_valid_q;
    logic              frame_error_q;

    always_ff @(posedge TenMHzToData) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_word_q     <= '0;
            word_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            word_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (f_s) begin
                        state <= START;
                        cnt   <= CNT_W'(1);
                    end
                end
                // cnt holds the number of high samples seen so far
                START: begin
                    if (f_s) begin
                        cnt <= cnt_inc(cnt);
                    end else if (cnt >= FLAG_CNT) begin
                        state <= GAP;
                        cnt   <= CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (f_s) begin
                        frame_error_q <= 1'b1;
                        state         <= IDLE;
                    end else if (cnt == GAP_CNT) begin
                        shreg[0] <= d_s;
                        bit_idx  <= IDX_W'(1);
                        state    <= SHIFT;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end
                SHIFT: begin
                    if (f_s) begin
                        frame_error_q <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        shreg[bit_idx] <= d_s;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= WAIT_END;
                            cnt   <= '0;
                        end
                    end
                end
                // A flag seen on the END_TIMEOUT-th cycle after the last bit
                // still counts; only then does the timeout fire.
                WAIT_END: begin
                    if (f_s) begin
                        state <= END;
                        cnt   <= CNT_W'(1);
                    end else if (cnt == TMO_CNT) begin
                        frame_error_q <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end
                END: begin
                    if (cnt == FLAG_CNT) begin
                        rx_word_q    <= shreg;
                        word_valid_q <= 1'b1;
                        state        <= DRAIN;
                    end else if (!f_s) begin
                        frame_error_q <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end
                // Hold off until the end flag clears so its tail is never
                // mistaken for the next start flag.
                DRAIN: begin
                    if (!f_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx.rx_word     = rx_word_q;
    assign rx.word_valid  = word_valid_q;
    assign rx.frame_error = frame_error_q;
    assign rx.busy        = (state != IDLE);

endmodule

// File: tb/tb_data_receive.sv
// Bench for data_receive: directed frame table, hand-written abort/reset
// sequences, and random frames scored against a frame-level outcome model.
module tb_data_receive;
    import data_link_pkg::*;

    localparam int FM = FLAG_MIN_DEF;
    localparam int GP = GAP_CYCLES_DEF;
    localparam int ET = END_TIMEOUT_DEF;

    logic clk = 1'b0;
    logic reset;
    data_receive_if bus();

    data_receive dut (.TenMHzToData(clk), .reset(reset), .rx(bus));

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int valid_cyc = -1;
    int err_cyc   = -1;
    int rise_cyc  = -1;
    int last_bit_cyc = -1;
    logic [WORD_W-1:0] prev_word = '0;
    logic [WORD_W-1:0] model_word;

    typedef struct {
        logic              full;   // 0: flag pulse only
        logic [WORD_W-1:0] w;
        int                st, eg, el;
        int                ev, ee;
        logic [WORD_W-1:0] ew;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.word_valid)  begin n_valid++; valid_cyc = cyc; end
                if (bus.frame_error) begin n_err++;   err_cyc   = cyc; end
                if (bus.word_valid || bus.frame_error)
                    check("strobe_exclusive", longint'(bus.word_valid & bus.frame_error), 0);
                if (bus.rx_word != prev_word)
                    check("rx_word_changes_only_on_valid", longint'(bus.word_valid), 1);
            end
            prev_word = bus.rx_word;
        end
    endtask

    task automatic drive(input logic f, input logic d);
        @(negedge clk);
        bus.dflag_in = f;
        bus.data_in  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    // Bit k is driven GP+k cycles after the first low pin cycle.
    // abort_bit raises dflag in that bit slot; rst_bit pulses reset there.
    task automatic send_frame(input logic [WORD_W-1:0] w, input int st, input int eg,
                              input int el, input int abort_bit, input int rst_bit);
        repeat (st) drive(1'b1, 1'b0);
        repeat (GP) drive(1'b0, 1'b0);
        for (int k = 0; k < WORD_W; k++) begin
            if (k == abort_bit) begin
                repeat (20) drive(1'b1, w[k]);
                idle(10);
                return;
            end
            if (k == rst_bit) begin
                check("busy_in_shift", longint'(bus.busy), 1);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check("rst_mid_rx_word", longint'(bus.rx_word), 0);
                check("rst_mid_word_valid", longint'(bus.word_valid), 0);
                check("rst_mid_frame_error", longint'(bus.frame_error), 0);
                check("rst_mid_busy", longint'(bus.busy), 0);
                @(negedge clk);
                reset = 1'b0;
                bus.dflag_in = 1'b0;
                bus.data_in  = 1'b0;
                idle(10);
                return;
            end
            drive(1'b0, w[k]);
            last_bit_cyc = cyc;
        end
        idle(eg);
        if (el > 0) begin
            drive(1'b1, 1'b0);
            rise_cyc = cyc;
            repeat (el - 1) drive(1'b1, 1'b0);
            idle(10);
        end else begin
            idle(ET + 20);
        end
    endtask

    task automatic expect_frame(input string name, input int v0, input int e0,
                                input int ev, input int ee, input logic [WORD_W-1:0] ew);
        check({name, "_valid_cnt"}, longint'(n_valid - v0), longint'(ev));
        check({name, "_error_cnt"}, longint'(n_err - e0), longint'(ee));
        check({name, "_rx_word"}, longint'(bus.rx_word), longint'(ew));
        check({name, "_busy_idle"}, longint'(bus.busy), 0);
    endtask

    // Frame-level outcome: what a correct receiver must report for a frame
    // described only by its flag lengths and end-flag distance.
    task automatic predict(input int st, input int eg, input int el, input logic [WORD_W-1:0] w,
                           output int ev, output int ee);
        ev = 0; ee = 0;
        if (st < FM) begin
            ev = 0; ee = 0;
        end else if (el == 0 || eg + 1 > ET || el < FM) begin
            ee = 1;
        end else begin
            ev = 1;
            model_word = w;
        end
    endtask

    initial begin
        int v0, e0, ev, ee, st, eg, el, kind;
        logic [31:0] r32;
        logic [WORD_W-1:0] w;

        tbl[0] = '{1'b1, 18'h2A5C3, 1000, 1000, 1000, 1, 0, 18'h2A5C3};
        tbl[1] = '{1'b0, 18'h00000,  100,    0,    0, 0, 0, 18'h2A5C3};
        tbl[2] = '{1'b1, 18'h1F0F0, 1000,    0,    0, 0, 1, 18'h2A5C3};
        tbl[3] = '{1'b1, 18'h0F0F0, 1000, 1000,  499, 0, 1, 18'h2A5C3};
        tbl[4] = '{1'b0, 18'h00000,  499,    0,    0, 0, 0, 18'h2A5C3};
        tbl[5] = '{1'b1, 18'h15555,  500, 1000,  500, 1, 0, 18'h15555};
        tbl[6] = '{1'b1, 18'h12345, 1000, 1000, 1000, 1, 0, 18'h12345};
        tbl[7] = '{1'b1, 18'h0ABCD, 1000, 1000, 1000, 1, 0, 18'h0ABCD};

        reset = 1'b1;
        bus.data_in  = 1'b0;
        bus.dflag_in = 1'b0;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        check("reset_rx_word", longint'(bus.rx_word), 0);
        check("reset_word_valid", longint'(bus.word_valid), 0);
        check("reset_frame_error", longint'(bus.frame_error), 0);
        check("reset_busy", longint'(bus.busy), 0);
        reset = 1'b0;
        idle(5);

        for (int i = 0; i < 8; i++) begin
            v0 = n_valid; e0 = n_err;
            if (tbl[i].full) send_frame(tbl[i].w, tbl[i].st, tbl[i].eg, tbl[i].el, -1, -1);
            else begin
                repeat (tbl[i].st) drive(1'b1, 1'b0);
                idle(20);
            end
            expect_frame($sformatf("tbl%0d", i), v0, e0, tbl[i].ev, tbl[i].ee, tbl[i].ew);
            if (tbl[i].ev == 1)
                check($sformatf("tbl%0d_valid_latency", i), longint'(valid_cyc - rise_cyc), FM + 3);
            if (tbl[i].full && tbl[i].el == 0)
                check($sformatf("tbl%0d_timeout_latency", i), longint'(err_cyc - last_bit_cyc), ET + 3);
        end

        // dflag forced high mid-data, then a clean all-ones frame
        v0 = n_valid; e0 = n_err;
        send_frame(18'h1B00F, 1000, 0, 0, 9, -1);
        expect_frame("abort_bit9", v0, e0, 0, 1, 18'h0ABCD);
        v0 = n_valid; e0 = n_err;
        send_frame(18'h3FFFF, 1000, 1000, 1000, -1, -1);
        expect_frame("after_abort", v0, e0, 1, 0, 18'h3FFFF);

        // reset during SHIFT, then a normal frame
        send_frame(18'h2AAAA, 1000, 0, 0, -1, 9);
        v0 = n_valid; e0 = n_err;
        send_frame(18'h00001, 1000, 1000, 1000, -1, -1);
        expect_frame("after_reset", v0, e0, 1, 0, 18'h00001);
        model_word = 18'h00001;

        for (int i = 0; i < 8; i++) begin
            kind = int'($urandom_range(0, 3));
            r32 = $urandom;
            w  = r32[WORD_W-1:0];
            st = int'($urandom_range(FM + 5, 800));
            eg = int'($urandom_range(10, 800));
            el = int'($urandom_range(FM + 5, 800));
            if (kind == 0) st = int'($urandom_range(5, FM - 5));
            if (kind == 2) el = 0;
            if (kind == 3) el = int'($urandom_range(50, FM - 5));
            v0 = n_valid; e0 = n_err;
            if (st < FM) begin
                repeat (st) drive(1'b1, 1'b0);
                idle(20);
            end else begin
                send_frame(w, st, eg, el, -1, -1);
            end
            predict(st, eg, el, w, ev, ee);
            expect_frame($sformatf("rand%0d_k%0d", i, kind), v0, e0, ev, ee, model_word);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
